// File: rtl/wb_pkg.sv
// Shared write-back types and defaults, used by the register file, the MEM/WB stage
// and the write-back writer.
package wb_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // A source may only be accepted while a same-cycle pair would still fit.
   function automatic logic wbHasRoom(input int depth, input int count);
      return (depth - count) >= 2;
   endfunction

endpackage

// File: rtl/regfile_wb_writer_if.sv
// Write-back result sources (load and ALU) with valid/ready handshakes.
// The MEM/WB stage drives the master side; the write-back writer is the slave.
interface regfile_wb_writer_if import wb_pkg::*; ();

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;

   modport master (
      output mem_valid, mem_addr, mem_data,
      output alu_valid, alu_addr, alu_data,
      input  mem_ready, alu_ready
   );

   modport slave (
      input  mem_valid, mem_addr, mem_data,
      input  alu_valid, alu_addr, alu_data,
      output mem_ready, alu_ready
   );

endinterface

// File: rtl/wb_fifo.sv
// Two-push / one-pop circular queue of pending write-backs. push1 is only used together
// with push0 and is the younger of the pair. aged_o lists entries from oldest (index 0).
module wb_fifo import wb_pkg::*; #(
   parameter  int DEPTH = wb_pkg::DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push0_i,
   input  wb_entry_t               push0Data_i,
   input  logic                    push1_i,
   input  wb_entry_t               push1Data_i,
   input  logic                    pop_i,
   output wb_entry_t               head_o,
   output logic [CNT_W-1:0]        count_o,
   output wb_entry_t [DEPTH-1:0]   aged_o,
   output logic [DEPTH-1:0]        agedValid_o
);

   wb_entry_t         mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W-1:0]  tailNext;
   logic [CNT_W-1:0]  count_q, count_d;

   assign tailNext = tail_q + PTR_W'(1);
   assign head_d   = head_q + PTR_W'(pop_i);
   assign tail_d   = tail_q + PTR_W'(push0_i) + PTR_W'(push1_i);
   assign count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push0_i) mem_q[tail_q]   <= push0Data_i;
      if (push1_i) mem_q[tailNext] <= push1Data_i;
   end

   always_comb begin
      aged_o      = '0;
      agedValid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         aged_o[i]      = mem_q[head_q + PTR_W'(i)];
         agedValid_o[i] = CNT_W'(i) < count_q;
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_writer.sv
// Serialises load and ALU results onto the register file's single write port.
// Define WB_FWD_EN to build the forwarding lookup; otherwise fwd_* outputs are tied to 0.
module regfile_wb_writer import wb_pkg::*; #(
   parameter  int DEPTH = wb_pkg::DEPTH,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_wb_writer_if.slave    src,
   output logic                  rf_we_o,
   output logic [ADDR_W-1:0]     rf_waddr_o,
   output logic [DATA_W-1:0]     rf_wdata_o,
   input  logic [ADDR_W-1:0]     fwd_addr_1_i,
   input  logic [ADDR_W-1:0]     fwd_addr_2_i,
   output logic                  fwd_hit_1_o,
   output logic                  fwd_hit_2_o,
   output logic [DATA_W-1:0]     fwd_data_1_o,
   output logic [DATA_W-1:0]     fwd_data_2_o
);

   logic                 ready;
   logic                 memAcc, aluAcc;
   wb_entry_t            memEntry, aluEntry;
   logic                 pop, push0, push1;
   wb_entry_t            push0Data, push1Data;
   wb_entry_t            head;
   logic [CNT_W-1:0]     count;
   wb_entry_t [DEPTH-1:0] aged;
   logic [DEPTH-1:0]     agedValid;
   logic                 rfWe_q, rfWe_d;
   wb_entry_t            rfEntry_q, rfEntry_d;

   assign ready         = wbHasRoom(DEPTH, int'(count));
   assign src.mem_ready = ready;
   assign src.alu_ready = ready;
   assign memAcc        = src.mem_valid & ready;
   assign aluAcc        = src.alu_valid & ready;
   assign memEntry      = '{addr: src.mem_addr, data: src.mem_data};
   assign aluEntry      = '{addr: src.alu_addr, data: src.alu_data};

   // The oldest of {queue head, mem, alu} goes to the write port; the rest queue up in age order.
   always_comb begin
      pop       = 1'b0;
      push0     = 1'b0;
      push1     = 1'b0;
      push0Data = memEntry;
      push1Data = aluEntry;
      rfWe_d    = 1'b0;
      rfEntry_d = rfEntry_q;
      if (count != '0) begin
         pop       = 1'b1;
         rfWe_d    = 1'b1;
         rfEntry_d = head;
         push0     = memAcc | aluAcc;
         push0Data = memAcc ? memEntry : aluEntry;
         push1     = memAcc & aluAcc;
      end else if (memAcc) begin
         rfWe_d    = 1'b1;
         rfEntry_d = memEntry;
         push0     = aluAcc;
         push0Data = aluEntry;
      end else if (aluAcc) begin
         rfWe_d    = 1'b1;
         rfEntry_d = aluEntry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rfWe_q    <= 1'b0;
         rfEntry_q <= '0;
      end else begin
         rfWe_q    <= rfWe_d;
         rfEntry_q <= rfEntry_d;
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push0_i     (push0),
      .push0Data_i (push0Data),
      .push1_i     (push1),
      .push1Data_i (push1Data),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count),
      .aged_o      (aged),
      .agedValid_o (agedValid)
   );

   assign rf_we_o    = rfWe_q;
   assign rf_waddr_o = rfEntry_q.addr;
   assign rf_wdata_o = rfEntry_q.data;

`ifdef WB_FWD_EN
   // Scan from oldest (write port) to youngest (queue tail) so the last match wins.
   function automatic logic [DATA_W:0] fwdLookup(
      input logic [ADDR_W-1:0]    a,
      input logic                 we,
      input wb_entry_t            rfE,
      input wb_entry_t [DEPTH-1:0] q,
      input logic [DEPTH-1:0]     qv
   );
      logic [DATA_W:0] r;
      r = '0;
      if (we && rfE.addr == a) r = {1'b1, rfE.data};
      for (int i = 0; i < DEPTH; i++) begin
         if (qv[i] && q[i].addr == a) r = {1'b1, q[i].data};
      end
      return r;
   endfunction

   assign {fwd_hit_1_o, fwd_data_1_o} = fwdLookup(fwd_addr_1_i, rfWe_q, rfEntry_q, aged, agedValid);
   assign {fwd_hit_2_o, fwd_data_2_o} = fwdLookup(fwd_addr_2_i, rfWe_q, rfEntry_q, aged, agedValid);
`else
   logic fwd_unused;
   assign fwd_unused   = ^{fwd_addr_1_i, fwd_addr_2_i, aged, agedValid};
   assign fwd_hit_1_o  = 1'b0;
   assign fwd_hit_2_o  = 1'b0;
   assign fwd_data_1_o = '0;
   assign fwd_data_2_o = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Self-checking bench for regfile_wb_writer: directed cases with literal expectations plus
// randomized traffic checked every cycle against a queue-based model of pending writes.
module tb_regfile_wb_writer;
   import wb_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rfWe;
   logic [ADDR_W-1:0] rfWaddr;
   logic [DATA_W-1:0] rfWdata;
   logic [ADDR_W-1:0] fwdAddr1, fwdAddr2;
   logic              fwdHit1, fwdHit2;
   logic [DATA_W-1:0] fwdData1, fwdData2;

   int total = 0;
   int bad   = 0;
   int hsCnt = 0;
   int wrCnt = 0;

   logic [DATA_W-1:0] regsTb [8];

   wb_entry_t mq [$];
   logic      mWe;
   wb_entry_t mRf;
   bit        mRdy;

   always #5 clk = ~clk;

   regfile_wb_writer_if bus ();

   regfile_wb_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .src          (bus),
      .rf_we_o      (rfWe),
      .rf_waddr_o   (rfWaddr),
      .rf_wdata_o   (rfWdata),
      .fwd_addr_1_i (fwdAddr1),
      .fwd_addr_2_i (fwdAddr2),
      .fwd_hit_1_o  (fwdHit1),
      .fwd_hit_2_o  (fwdHit2),
      .fwd_data_1_o (fwdData1),
      .fwd_data_2_o (fwdData2)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                                input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
      bus.mem_valid = mv;
      bus.mem_addr  = ma;
      bus.mem_data  = md;
      bus.alu_valid = av;
      bus.alu_addr  = aa;
      bus.alu_data  = ad;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Model: every accepted write joins one in-order list; each cycle the oldest leaves to rf.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mWe = 1'b0;
         mRf = '0;
      end else begin
         mRdy = (DEPTH - mq.size()) >= 2;
         if (mRdy && bus.mem_valid) mq.push_back(wb_entry_t'{bus.mem_addr, bus.mem_data});
         if (mRdy && bus.alu_valid) mq.push_back(wb_entry_t'{bus.alu_addr, bus.alu_data});
         if (mq.size() > 0) begin
            mRf = mq.pop_front();
            mWe = 1'b1;
         end else begin
            mWe = 1'b0;
         end
      end
   end

   function automatic logic [DATA_W:0] modelFwd(input logic [ADDR_W-1:0] a);
      logic [DATA_W:0] r;
      r = '0;
`ifdef WB_FWD_EN
      if (mWe && mRf.addr == a) r = {1'b1, mRf.data};
      foreach (mq[i]) if (mq[i].addr == a) r = {1'b1, mq[i].data};
`else
      if (a === 'x) r = '0;
`endif
      return r;
   endfunction

   always @(negedge clk) begin
      logic [DATA_W:0] f1, f2;
      logic            rdy;
      f1  = modelFwd(fwdAddr1);
      f2  = modelFwd(fwdAddr2);
      rdy = (DEPTH - mq.size()) >= 2;
      checkOutput("cmp rf_we",      32'(rfWe),          32'(mWe));
      checkOutput("cmp rf_waddr",   32'(rfWaddr),       32'(mRf.addr));
      checkOutput("cmp rf_wdata",   32'(rfWdata),       32'(mRf.data));
      checkOutput("cmp mem_ready",  32'(bus.mem_ready), 32'(rdy));
      checkOutput("cmp alu_ready",  32'(bus.alu_ready), 32'(rdy));
      checkOutput("cmp fwd_hit_1",  32'(fwdHit1),       32'(f1[DATA_W]));
      checkOutput("cmp fwd_data_1", 32'(fwdData1),      32'(f1[DATA_W-1:0]));
      checkOutput("cmp fwd_hit_2",  32'(fwdHit2),       32'(f2[DATA_W]));
      checkOutput("cmp fwd_data_2", 32'(fwdData2),      32'(f2[DATA_W-1:0]));
      if (rfWe === 1'b1) wrCnt++;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         hsCnt += int'(bus.mem_valid && bus.mem_ready) + int'(bus.alu_valid && bus.alu_ready);
         if (rfWe) regsTb[rfWaddr] <= rfWdata;
      end
   end

   localparam logic EXP_FWD =
`ifdef WB_FWD_EN
      1'b1;
`else
      1'b0;
`endif

   initial begin
      rst_n    = 1'b0;
      fwdAddr1 = '0;
      fwdAddr2 = '0;
      foreach (regsTb[i]) regsTb[i] = '0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checkOutput("reset rf_we",     32'(rfWe), 0);
      checkOutput("reset rf_waddr",  32'(rfWaddr), 0);
      checkOutput("reset rf_wdata",  32'(rfWdata), 0);
      checkOutput("reset mem_ready", 32'(bus.mem_ready), 1);
      checkOutput("reset alu_ready", 32'(bus.alu_ready), 1);
      checkOutput("reset fwd_hit_1", 32'(fwdHit1), 0);
      checkOutput("reset fwd_hit_2", 32'(fwdHit2), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Lone ALU write to R2.
      applyStimulus(0, 0, 0, 1, 2, 16'h5555);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("lone rf_we",    32'(rfWe), 1);
      checkOutput("lone rf_waddr", 32'(rfWaddr), 2);
      checkOutput("lone rf_wdata", 32'(rfWdata), 32'h5555);
      stepCycle();
      checkOutput("lone rf_we off", 32'(rfWe), 0);
      checkOutput("lone R2 readback", 32'(regsTb[2]), 32'h5555);

      // Same-cycle pair: mem is older.
      applyStimulus(1, 1, 16'hFFFF, 1, 5, 16'h6666);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("pair c1 addr", 32'(rfWaddr), 1);
      checkOutput("pair c1 data", 32'(rfWdata), 32'hFFFF);
      stepCycle();
      checkOutput("pair c2 we",   32'(rfWe), 1);
      checkOutput("pair c2 addr", 32'(rfWaddr), 5);
      checkOutput("pair c2 data", 32'(rfWdata), 32'h6666);
      stepCycle();
      checkOutput("pair c3 we",   32'(rfWe), 0);

      // Forwarding: two pending writes to R3, youngest wins.
      fwdAddr1 = 3;
      fwdAddr2 = 4;
      applyStimulus(1, 3, 16'h1111, 1, 3, 16'h2222);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("fwd hit_1",  32'(fwdHit1), 32'(EXP_FWD));
      checkOutput("fwd data_1", 32'(fwdData1), EXP_FWD ? 32'h2222 : 32'h0);
      checkOutput("fwd hit_2",  32'(fwdHit2), 0);
      stepCycle();
      checkOutput("fwd rf-only data_1", 32'(fwdData1), EXP_FWD ? 32'h2222 : 32'h0);
      stepCycle();
      checkOutput("fwd drained hit_1", 32'(fwdHit1), 0);

      // Both sources valid for six cycles: 2+2+2+0+2+0 accepted.
      hsCnt = 0;
      wrCnt = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 3'(i), 16'hA000 + 16'(i), 1, 3'(i + 1), 16'hB000 + 16'(i));
         stepCycle();
         if (i == 2) checkOutput("burst ready low", 32'(bus.mem_ready), 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (6) stepCycle();
      checkOutput("burst accepted", 32'(hsCnt), 8);
      checkOutput("burst written",  32'(wrCnt), 8);

      // Reset with three writes queued discards them.
      applyStimulus(1, 1, 16'hC001, 1, 2, 16'hC002);
      stepCycle();
      applyStimulus(1, 3, 16'hC003, 1, 4, 16'hC004);
      stepCycle();
      applyStimulus(1, 5, 16'hC005, 1, 6, 16'hC006);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("pre-reset ready low", 32'(bus.mem_ready), 0);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset rf_we",    32'(rfWe), 0);
      checkOutput("midreset rf_wdata", 32'(rfWdata), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         checkOutput("post-reset rf_we", 32'(rfWe), 0);
      end

      // Randomized traffic with one reset in the middle.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) < 6, 3'($urandom), 16'($urandom),
                       $urandom_range(0, 9) < 6, 3'($urandom), 16'($urandom));
         fwdAddr1 = 3'($urandom);
         fwdAddr2 = 3'($urandom);
         if (i == 200) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         stepCycle();
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (8) stepCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
